hs_cdc_2phase_tx: RTL and testbench

HS_CDC_2PHASE_TX -- requirements
Module: hs_cdc_2phase_tx

---
 rtl/hs_cdc_2phase_tx.sv | 143 ++++++++++++++
 tb/tb_hs_cdc_2phase_tx.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_cdc_2phase_tx.sv
// Two-phase (toggle) request/ack CDC transmitter with bundled data,
// ack synchronizer, optional ack timeout and spurious-ack detection.
package hs_cdc_pkg;
    typedef enum logic {BOOL_FALSE = 1'b0, BOOL_TRUE = 1'b1} bool_t;
endpackage

module hs_cdc_2phase_tx
    import hs_cdc_pkg::*;
#(
    parameter type      DATA_TYPE       = logic,
    parameter bool_t    RESET_DATA_PATH = BOOL_FALSE,
    parameter DATA_TYPE RESET_VALUE     = DATA_TYPE'(1'b0),
    parameter int       SYNC_STAGE      = 2,
    parameter int       TIMEOUT_CYCLES  = 0
) (
    input  logic     clk,
    input  logic     aresetn,
    input  DATA_TYPE in_data,
    input  logic     in_valid,
    output logic     in_ready,
    output DATA_TYPE tx_data,
    output logic     tx_req,
    input  logic     tx_ack_async,
    output logic     busy,
    output logic     timeout_err,
    output logic     proto_err,
    input  logic     err_clr
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                state;
    logic [SYNC_STAGE-1:0] ack_sync;
    logic                  ack_s;
    logic                  accept;

    assign ack_s  = ack_sync[SYNC_STAGE-1];
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGE-2:0], tx_ack_async};
        end
    end

    // in_ready/busy are kept as flops mirroring the state
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            tx_req   <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= WAIT_ACK;
                        tx_req   <= ~tx_req;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s == tx_req) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RESET_DATA_PATH == BOOL_TRUE) begin : g_data_rst
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    tx_data <= RESET_VALUE;
                end else if (accept) begin
                    tx_data <= in_data;
                end
            end
        end else begin : g_data_norst
            // no reset on the data flop, but never load while held in reset
            always_ff @(posedge clk) begin
                if (accept && aresetn) begin
                    tx_data <= in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            proto_err <= 1'b0;
        end else if (state == IDLE && ack_s != tx_req) begin
            proto_err <= 1'b1;
        end else if (err_clr) begin
            proto_err <= 1'b0;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_to
            localparam int           CW   = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] cnt;
            logic          terr;

            // flag fires once, on the edge where the count reaches its cap
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    cnt  <= '0;
                    terr <= 1'b0;
                end else begin
                    if (accept) begin
                        cnt <= '0;
                    end else if (state == WAIT_ACK && cnt != CMAX) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (state == WAIT_ACK && cnt == CMAX - CW'(1)) begin
                        terr <= 1'b1;
                    end else if (err_clr) begin
                        terr <= 1'b0;
                    end
                end
            end

            assign timeout_err = terr;
        end else begin : g_no_to
            assign timeout_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_hs_cdc_2phase_tx.sv
// Self-checking bench for hs_cdc_2phase_tx: directed scenarios plus
// randomized transfers checked against a transaction-level timing model.
module tb_hs_cdc_2phase_tx;
    import hs_cdc_pkg::*;

    typedef logic [7:0] byte_t;

    localparam int S_MAIN = 2;
    localparam int TO     = 8;
    localparam int SS [6] = '{2, 2, 3, 3, 32, 32};

    logic  clk;
    logic  aresetn;
    byte_t in_data;
    logic  in_valid;
    logic  in_ready;
    byte_t tx_data;
    logic  tx_req;
    logic  tx_ack;
    logic  busy;
    logic  terr;
    logic  perr;
    logic  err_clr;

    byte_t      sw_data;
    logic       sw_valid;
    logic       sw_ack;
    logic       sw_clr;
    logic [5:0] sw_ready;
    logic [5:0] sw_req;
    logic [5:0] sw_busy;
    logic [5:0] sw_terr;
    logic [5:0] sw_perr;
    byte_t      sw_txd [6];

    int checks = 0;
    int errors = 0;

    hs_cdc_2phase_tx #(
        .DATA_TYPE      (byte_t),
        .RESET_DATA_PATH(BOOL_TRUE),
        .RESET_VALUE    (8'h3C),
        .SYNC_STAGE     (S_MAIN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .tx_ack_async(tx_ack),
        .busy        (busy),
        .timeout_err (terr),
        .proto_err   (perr),
        .err_clr     (err_clr)
    );

    for (genvar g = 0; g < 6; g++) begin : g_sw
        hs_cdc_2phase_tx #(
            .DATA_TYPE      (byte_t),
            .RESET_DATA_PATH(bool_t'(g % 2)),
            .RESET_VALUE    (8'h5A),
            .SYNC_STAGE     (SS[g]),
            .TIMEOUT_CYCLES (0)
        ) u_sw (
            .clk         (clk),
            .aresetn     (aresetn),
            .in_data     (sw_data),
            .in_valid    (sw_valid),
            .in_ready    (sw_ready[g]),
            .tx_data     (sw_txd[g]),
            .tx_req      (sw_req[g]),
            .tx_ack_async(sw_ack),
            .busy        (sw_busy[g]),
            .timeout_err (sw_terr[g]),
            .proto_err   (sw_perr[g]),
            .err_clr     (sw_clr)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        in_valid = 1'b0;
        sw_valid = 1'b0;
        tx_ack   = 1'b0;
        sw_ack   = 1'b0;
        err_clr  = 1'b0;
        sw_clr   = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        sw_valid = 1'b1;
        sw_data  = 8'hEE;
        tx_ack   = 1'b0;
        sw_ack   = 1'b0;
        err_clr  = 1'b0;
        sw_clr   = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_hs: ready=%b busy=%b want 1/0", in_ready, busy);
        end
        checks++;
        if (tx_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req: got %b want 0", tx_req);
        end
        checks++;
        if (tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL rst_data: got %h want 3c", tx_data);
        end
        checks++;
        if (terr !== 1'b0 || perr !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: terr=%b perr=%b want 0/0", terr, perr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sw_ready[i] !== 1'b1 || sw_busy[i] !== 1'b0 ||
                sw_req[i] !== 1'b0) begin
                errors++;
                $display("FAIL rst_sw%0d: rdy=%b busy=%b req=%b want 1/0/0",
                         i, sw_ready[i], sw_busy[i], sw_req[i]);
            end
            if (i % 2 == 1) begin
                checks++;
                if (sw_txd[i] !== 8'h5A) begin
                    errors++;
                    $display("FAIL rst_sw%0d_data: got %h want 5a", i, sw_txd[i]);
                end
            end
        end
        in_valid = 1'b0;
        sw_valid = 1'b0;
        aresetn  = 1'b1;
        tick();
        checks++;
        if (tx_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: req=%b rdy=%b want 0/1", tx_req, in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (tx_data !== 8'hA5 || tx_req !== 1'b1) begin
            errors++;
            $display("FAIL single_acc: data=%h req=%b want a5/1", tx_data, tx_req);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (busy !== (e < 6) || in_ready !== !(e < 6)) begin
                errors++;
                $display("FAIL single_busy e%0d: busy=%b rdy=%b want %b/%b",
                         e, busy, in_ready, e < 6, !(e < 6));
            end
            if (e == 3) tx_ack = 1'b1;
        end
        checks++;
        if (tx_data !== 8'hA5 || perr !== 1'b0) begin
            errors++;
            $display("FAIL single_end: data=%h perr=%b want a5/0", tx_data, perr);
        end
    endtask

    task automatic test_back_to_back();
        byte_t vals [3] = '{8'h01, 8'h02, 8'h03};
        int    busy_len = 1 + S_MAIN + 1;
        int    k = 0;
        int    since = -1;
        int    ntog = 0;
        logic  exp_req = 1'b0;
        logic  prev_req;
        logic  acc_m;
        byte_t cur;
        do_reset();
        prev_req = 1'b0;
        cur      = 8'h3C;
        in_data  = vals[0];
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            acc_m = in_valid && (since < 0 || since >= busy_len);
            tick();
            if (acc_m) begin
                exp_req = ~exp_req;
                cur     = vals[k];
                checks++;
                if (tx_req !== exp_req || tx_data !== cur) begin
                    errors++;
                    $display("FAIL b2b_acc%0d: req=%b data=%h want %b/%h",
                             k, tx_req, tx_data, exp_req, cur);
                end
                k++;
                since = 0;
                if (k < 3) in_data = vals[k];
                else in_valid = 1'b0;
            end else if (since >= 0) begin
                since++;
            end
            if (since == 1) tx_ack = ~tx_ack;
            if (since >= 0) begin
                checks++;
                if (busy !== (since < busy_len) || tx_data !== cur) begin
                    errors++;
                    $display("FAIL b2b_hold c%0d: busy=%b data=%h want %b/%h",
                             c, busy, tx_data, since < busy_len, cur);
                end
            end
            if (tx_req !== prev_req) ntog++;
            prev_req = tx_req;
        end
        checks++;
        if (ntog != 3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: toggles=%0d rdy=%b want 3/1", ntog, in_ready);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        in_data  = byte_t'($urandom);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (terr !== (e >= TO) || busy !== 1'b1 || tx_req !== 1'b1) begin
                errors++;
                $display("FAIL to_wait e%0d: terr=%b busy=%b req=%b want %b/1/1",
                         e, terr, busy, tx_req, e >= TO);
            end
        end
        tx_ack = 1'b1;
        for (int e = 13; e <= 15; e++) begin
            tick();
            checks++;
            if (busy !== (e < 15) || terr !== 1'b1) begin
                errors++;
                $display("FAIL to_late e%0d: busy=%b terr=%b want %b/1",
                         e, busy, terr, e < 15);
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (terr !== 1'b0) begin
            errors++;
            $display("FAIL to_clr: terr=%b want 0", terr);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        tx_ack = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (perr !== (e >= S_MAIN + 1) || tx_req !== 1'b0 ||
                in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sp_set e%0d: perr=%b req=%b rdy=%b want %b/0/1",
                         e, perr, tx_req, in_ready, e >= S_MAIN + 1);
            end
        end
        tx_ack = 1'b0;
        repeat (S_MAIN + 1) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL sp_clr: perr=%b want 0", perr);
        end
        tx_ack = 1'b1;
        repeat (S_MAIN) tick();
        err_clr = 1'b1;
        tick();
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL sp_setwins: perr=%b want 1", perr);
        end
        err_clr = 1'b0;
        checks++;
        if (terr !== 1'b0 || tx_req !== 1'b0) begin
            errors++;
            $display("FAIL sp_side: terr=%b req=%b want 0/0", terr, tx_req);
        end
    endtask

    task automatic test_reset_mid();
        byte_t d;
        do_reset();
        in_data  = byte_t'($urandom);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (TO) tick();
        checks++;
        if (terr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rm_pre: terr=%b busy=%b want 1/1", terr, busy);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (tx_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            terr !== 1'b0 || perr !== 1'b0 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL rm_async: req=%b busy=%b rdy=%b terr=%b perr=%b data=%h want 0/0/1/0/0/3c",
                     tx_req, busy, in_ready, terr, perr, tx_data);
        end
        tick();
        aresetn = 1'b1;
        d        = byte_t'($urandom);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (tx_req !== 1'b1 || tx_data !== d) begin
            errors++;
            $display("FAIL rm_acc: req=%b data=%h want 1/%h", tx_req, tx_data, d);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 2) tx_ack = 1'b1;
            checks++;
            if (busy !== (e < 2 + S_MAIN + 1)) begin
                errors++;
                $display("FAIL rm_done e%0d: busy=%b want %b", e, busy,
                         e < 2 + S_MAIN + 1);
            end
        end
    endtask

    task automatic test_random();
        logic  req_m = 1'b0;
        logic  terr_m = 1'b0;
        byte_t d;
        int    a;
        int    blen;
        logic  junk;
        do_reset();
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 2)) tick();
            d    = byte_t'($urandom);
            a    = $urandom_range(0, 7);
            junk = 1'($urandom);
            blen = a + S_MAIN + 1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready t%0d: got %b want 1", t, in_ready);
            end
            in_data  = d;
            in_valid = 1'b1;
            tick();
            req_m = ~req_m;
            if (blen >= TO) terr_m = 1'b1;
            in_valid = junk;
            in_data  = ~d;
            checks++;
            if (tx_req !== req_m || tx_data !== d) begin
                errors++;
                $display("FAIL rnd_acc t%0d: req=%b data=%h want %b/%h",
                         t, tx_req, tx_data, req_m, d);
            end
            if (a == 0) tx_ack = ~tx_ack;
            for (int e = 1; e <= blen; e++) begin
                tick();
                if (e == a) tx_ack = ~tx_ack;
                if (e == blen) in_valid = 1'b0;
                checks++;
                if (busy !== (e < blen) || tx_data !== d || tx_req !== req_m) begin
                    errors++;
                    $display("FAIL rnd_busy t%0d e%0d: busy=%b data=%h req=%b want %b/%h/%b",
                             t, e, busy, tx_data, tx_req, e < blen, d, req_m);
                end
            end
            checks++;
            if (terr !== terr_m) begin
                errors++;
                $display("FAIL rnd_terr t%0d: got %b want %b", t, terr, terr_m);
            end
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                terr_m  = 1'b0;
            end
        end
        checks++;
        if (perr !== 1'b0 || terr !== terr_m) begin
            errors++;
            $display("FAIL rnd_end: perr=%b terr=%b want 0/%b", perr, terr, terr_m);
        end
    endtask

    task automatic test_sweep();
        int    done_at [6];
        int    a;
        int    edge_n;
        byte_t d;
        logic  exp_req = 1'b0;
        do_reset();
        for (int run = 0; run < 2; run++) begin
            d        = byte_t'($urandom);
            sw_data  = d;
            sw_valid = 1'b1;
            tick();
            sw_valid = 1'b0;
            exp_req  = ~exp_req;
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (sw_busy[i] !== 1'b1 || sw_req[i] !== exp_req ||
                    sw_txd[i] !== d) begin
                    errors++;
                    $display("FAIL sw_acc r%0d i%0d: busy=%b req=%b data=%h want 1/%b/%h",
                             run, i, sw_busy[i], sw_req[i], sw_txd[i], exp_req, d);
                end
                done_at[i] = -1;
            end
            a = $urandom_range(0, 3);
            repeat (a) tick();
            sw_ack = ~sw_ack;
            edge_n = a;
            for (int s = 0; s < 40; s++) begin
                tick();
                edge_n++;
                for (int i = 0; i < 6; i++) begin
                    if (done_at[i] < 0 && sw_busy[i] === 1'b0) done_at[i] = edge_n;
                end
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (done_at[i] != a + SS[i] + 1 || sw_ready[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL sw_lat r%0d i%0d: done=%0d rdy=%b want %0d/1",
                             run, i, done_at[i], sw_ready[i], a + SS[i] + 1);
                end
                checks++;
                if (sw_terr[i] !== 1'b0 || sw_perr[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL sw_flags r%0d i%0d: terr=%b perr=%b want 0/0",
                             run, i, sw_terr[i], sw_perr[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
